// File: rtl/bit_corner_turn.sv
`default_nettype none
// ============================================================================
//  Module   : bit_corner_turn
//  Purpose  : N x N bit-matrix corner turn. Accepts N row words over a
//             valid/ready stream and emits N column words; column j bit i
//             equals row i bit j.
//  Options  : BIT_CORNER_TURN_PINGPONG_EN - two banks so that filling one
//             matrix overlaps draining the previous one. Undefined gives a
//             single bank that alternates fill and drain.
//  Revision : 1.0 - initial release
// ============================================================================
module bit_corner_turn #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

`ifdef BIT_CORNER_TURN_PINGPONG_EN
  localparam bit C_PINGPONG = 1'b1;
`else
  localparam bit C_PINGPONG = 1'b0;
`endif

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Two bank slots always exist; without ping-pong both pointers are pinned
  // to bank 0 and bank 1 never leaves its reset state.
  logic [N-1:0]  mem_q   [2][N];
  logic [N-1:0]  mem_d   [2][N];
  state_t        state_q [2];
  state_t        state_d [2];
  logic [CW-1:0] cnt_q   [2];
  logic [CW-1:0] cnt_d   [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;

  logic          in_fire;
  logic          out_fire;
  logic [CW-1:0] rd_col;

  // Output decode from registered state; reset forces every output low.
  always_comb begin
    in_ready  = ~rst && (state_q[wr_ptr_q] == FILL);
    out_valid = ~rst && (state_q[rd_ptr_q] == DRAIN);
    rd_col    = cnt_q[rd_ptr_q];
    out_data  = '0;
    out_last  = 1'b0;
    if (out_valid) begin
      for (int i = 0; i < N; i++) begin
        out_data[i] = mem_q[rd_ptr_q][i][rd_col];
      end
      out_last = (rd_col == C_LAST);
    end
    busy = 1'b0;
    for (int b = 0; b < 2; b++) begin
      if ((state_q[b] == DRAIN) || (cnt_q[b] != '0)) begin
        busy = ~rst;
      end
    end
  end

  // Next-state: row write into the fill bank, column advance in the drain bank.
  always_comb begin
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    mem_d    = mem_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    // Fill and drain never target the same bank in the same cycle: the
    // write bank must be in FILL and the read bank in DRAIN.
    if (in_fire) begin
      mem_d[wr_ptr_q][cnt_q[wr_ptr_q]] = in_data;
      if (cnt_q[wr_ptr_q] == C_LAST) begin
        cnt_d[wr_ptr_q]   = '0;
        state_d[wr_ptr_q] = DRAIN;
        wr_ptr_d          = C_PINGPONG ? ~wr_ptr_q : 1'b0;
      end else begin
        cnt_d[wr_ptr_q] = cnt_q[wr_ptr_q] + 1'b1;
      end
    end

    if (out_fire) begin
      if (cnt_q[rd_ptr_q] == C_LAST) begin
        cnt_d[rd_ptr_q]   = '0;
        state_d[rd_ptr_q] = FILL;
        rd_ptr_d          = C_PINGPONG ? ~rd_ptr_q : 1'b0;
      end else begin
        cnt_d[rd_ptr_q] = cnt_q[rd_ptr_q] + 1'b1;
      end
    end
  end

  // Control registers with synchronous reset; matrix storage is not cleared
  // because gating of out_data keeps stale contents invisible.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= FILL;
        cnt_q[b]   <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bit_corner_turn.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bit_corner_turn
//  Purpose  : Directed self-checking bench for bit_corner_turn, N = 5.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bit_corner_turn;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_data;
  logic       out_last;
  logic       busy;

  int passed = 0;
  int total  = 0;

  logic [4:0] rows_a [5] = '{5'b10101, 5'b01111, 5'b00000, 5'b11111, 5'b00011};
  logic [4:0] cols_a [5] = '{5'b11011, 5'b11010, 5'b01011, 5'b01010, 5'b01001};
  logic [4:0] rows_b [5] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};
  logic [4:0] cols_b [5] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};

  bit_corner_turn #(.N(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one row and hold it until an edge accepts it (bounded).
  task automatic send_row(input logic [4:0] d);
    int k;
    k = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    if (k == 50) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // ---------------- basic transpose ----------------
    out_ready = 1'b1;
    for (int r = 0; r < 4; r++) send_row(rows_a[r]);
    chk("basic_no_early_valid", 32'(out_valid), 32'd0);
    chk("basic_busy_fill", 32'(busy), 32'd1);
    send_row(rows_a[4]);
    chk("basic_latency_valid", 32'(out_valid), 32'd1);
`ifndef BIT_CORNER_TURN_PINGPONG_EN
    chk("basic_in_ready_drain", 32'(in_ready), 32'd0);
`endif
    for (int j = 0; j < 5; j++) begin
      chk("basic_col", 32'(out_data), 32'(cols_a[j]));
      chk("basic_last", 32'(out_last), (j == 4) ? 32'd1 : 32'd0);
      tick();
    end
    chk("basic_done_valid", 32'(out_valid), 32'd0);
    chk("basic_done_ready", 32'(in_ready), 32'd1);
    chk("basic_done_busy", 32'(busy), 32'd0);

    // ---------------- backpressure at column 2 ----------------
    out_ready = 1'b0;
    for (int r = 0; r < 5; r++) send_row(rows_a[r]);
    out_ready = 1'b1;
    chk("bp_col0", 32'(out_data), 32'(cols_a[0]));
    tick();
    chk("bp_col1", 32'(out_data), 32'(cols_a[1]));
    tick();
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      chk("bp_hold_data", 32'(out_data), 32'(cols_a[2]));
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
`ifndef BIT_CORNER_TURN_PINGPONG_EN
      chk("bp_in_ready", 32'(in_ready), 32'd0);
`endif
      tick();
    end
    out_ready = 1'b1;
    for (int j = 2; j < 5; j++) begin
      chk("bp_col", 32'(out_data), 32'(cols_a[j]));
      chk("bp_last", 32'(out_last), (j == 4) ? 32'd1 : 32'd0);
      tick();
    end
    chk("bp_done_valid", 32'(out_valid), 32'd0);

    // ---------------- input gaps ----------------
    for (int r = 0; r < 5; r++) begin
      send_row(rows_a[r]);
      if (r < 4) begin
        chk("gap_busy_idle", 32'(busy), 32'd1);
        chk("gap_no_valid", 32'(out_valid), 32'd0);
        tick();
      end
    end
    for (int j = 0; j < 5; j++) begin
      chk("gap_col", 32'(out_data), 32'(cols_a[j]));
      chk("gap_busy_drain", 32'(busy), 32'd1);
      tick();
    end
    chk("gap_busy_done", 32'(busy), 32'd0);

    // ---------------- reset mid-fill ----------------
    for (int r = 0; r < 3; r++) send_row(5'b11111);
    rst = 1'b1;
    tick();
    chk("rstfill_in_ready", 32'(in_ready), 32'd0);
    chk("rstfill_out_valid", 32'(out_valid), 32'd0);
    chk("rstfill_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    #1;
    chk("rstfill_ready_after", 32'(in_ready), 32'd1);
    chk("rstfill_busy_after", 32'(busy), 32'd0);
    for (int r = 0; r < 4; r++) send_row(rows_b[r]);
    chk("rstfill_no_early_valid", 32'(out_valid), 32'd0);
    send_row(rows_b[4]);
    for (int j = 0; j < 5; j++) begin
      chk("rstfill_col", 32'(out_data), 32'(cols_b[j]));
      chk("rstfill_last", 32'(out_last), (j == 4) ? 32'd1 : 32'd0);
      tick();
    end

    // ---------------- reset mid-drain ----------------
    for (int r = 0; r < 5; r++) send_row(rows_a[r]);
    for (int j = 0; j < 2; j++) begin
      chk("rstdrain_col", 32'(out_data), 32'(cols_a[j]));
      tick();
    end
    rst = 1'b1;
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rstdrain_valid", 32'(out_valid), 32'd0);
      chk("rstdrain_data", 32'(out_data), 32'd0);
      chk("rstdrain_last", 32'(out_last), 32'd0);
      tick();
    end
    rst = 1'b0;
    #1;
    for (int s = 0; s < 4; s++) begin
      chk("rstdrain_after_valid", 32'(out_valid), 32'd0);
      chk("rstdrain_after_last", 32'(out_last), 32'd0);
      chk("rstdrain_after_ready", 32'(in_ready), 32'd1);
      tick();
    end

`ifdef BIT_CORNER_TURN_PINGPONG_EN
    // ---------------- ping-pong streaming ----------------
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_valid = (k < 15);
      in_data  = rows_a[k % 5];
      if (k < 15) chk("pp_in_ready", 32'(in_ready), 32'd1);
      chk("pp_out_valid", 32'(out_valid), (k >= 5) ? 32'd1 : 32'd0);
      if (k >= 5) begin
        chk("pp_col", 32'(out_data), 32'(cols_a[(k - 5) % 5]));
        chk("pp_last", 32'(out_last), (((k - 5) % 5) == 4) ? 32'd1 : 32'd0);
      end
      tick();
    end
    in_valid = 1'b0;
    chk("pp_done_valid", 32'(out_valid), 32'd0);
    chk("pp_done_busy", 32'(busy), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
